// File: rtl/prueba_counter.sv
// Free-running count_o stepped by a clock-enable prescaler; optional PRUEBA_SATURATE_EN holds at MAX_COUNT instead of wrapping.
// Latency: first step on the DIV-th rising edge after rst release, then one step every DIV edges.
// Backpressure: none; the counter free-runs and count_o is a plain registered level.
module prueba_counter #(
    parameter int DIV       = 10,
    parameter int MAX_COUNT = 63
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] count_o
);

    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [5:0]      TERM_VAL   = 6'(MAX_COUNT);

    if (DIV < 1 || MAX_COUNT > 63 || MAX_COUNT < 1) begin : g_param_check
        $error("prueba_counter: illegal parameters DIV=%0d MAX_COUNT=%0d", DIV, MAX_COUNT);
    end

    logic [PW-1:0] presc;
    logic          tick;

    // With DIV=1 the prescaler is a single bit pinned at zero, so tick is constant high.
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_o <= 6'd0;
        end else if (tick) begin
            if (count_o == TERM_VAL) begin
`ifdef PRUEBA_SATURATE_EN
                count_o <= TERM_VAL;
`else
                count_o <= 6'd0;
`endif
            end else begin
                count_o <= count_o + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_prueba_counter.sv
// Bench for prueba_counter: a DIV=10/MAX=63 instance and a DIV=1/MAX=3 instance share clk and rst.
// Expected counts are pushed per edge into queues; a separate monitor pops and compares.
module tb_prueba_counter;

    logic       clk;
    logic       rst;
    logic [5:0] count_a;
    logic [5:0] count_b;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    logic [5:0] qa[$];
    logic [5:0] qb[$];
    event       chk_ev;

    prueba_counter #(.DIV(10), .MAX_COUNT(63)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .count_o (count_a)
    );

    prueba_counter #(.DIV(1), .MAX_COUNT(3)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .count_o (count_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected count after n edges out of reset for a given divider and terminal value.
    function automatic logic [5:0] exp_cnt(input int n, input int div, input int maxc);
        int steps;
        steps = n / div;
`ifdef PRUEBA_SATURATE_EN
        if (steps > maxc) steps = maxc;
        return 6'(steps);
`else
        return 6'(steps % (maxc + 1));
`endif
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst) begin
                qa.push_back(6'd0);
                qb.push_back(6'd0);
            end else begin
                k++;
                qa.push_back(exp_cnt(k, 10, 63));
                qb.push_back(exp_cnt(k, 1, 3));
            end
        end
    endtask

    // Assert reset between edges and check the clear lands before the next edge.
    task automatic assert_rst_async();
        @(negedge clk);
        #5;
        rst = 1'b1;
        #1;
        qa.push_back(6'd0);
        qb.push_back(6'd0);
        -> chk_ev;
    endtask

    task automatic release_rst();
        @(negedge clk);
        #5;
        rst = 1'b0;
        k   = 0;
    endtask

    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(negedge clk or chk_ev);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                checks++;
                if (count_a !== e) begin
                    errors++;
                    $display("FAIL count_div10 t=%0t got %0d want %0d", $time, count_a, e);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                checks++;
                if (count_b !== e) begin
                    errors++;
                    $display("FAIL count_div1 t=%0t got %0d want %0d", $time, count_b, e);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        // Reset held across the first two edges (30 ns).
        step(2);
        release_rst();
        // Covers first step at edge 10, 63 at edge 630, wrap (or hold) at 640.
        step(660);

        assert_rst_async();
        step(2);
        release_rst();
        // Edge 54 leaves count=5 with prescaler=4.
        step(54);
        assert_rst_async();
        step(2);
        release_rst();
        // No partial prescale retained: next step at edge 10 again.
        step(25);

        // Long reset hold: 300 us at 20 ns per edge.
        assert_rst_async();
        step(15000);
        release_rst();
        step(5);

        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
